// File: rtl/pulse_train_generator_if.sv
// Pulse train generator bus.
// Groups the request, configuration and status signals of the pulse train
// generator so that a controller and the generator connect through a single port.
//   start, abort           request / cancel a train (master -> slave)
//   high_len, low_len      per-pulse high and low phase lengths in cycles
//   num_pulses             number of pulses in the train
//   out, busy, done        train output and status (slave -> master)
interface pulse_train_generator_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] num_pulses;
    logic             out;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, high_len, low_len, num_pulses,
        input  out, busy, done
    );

    modport slave (
        input  start, abort, high_len, low_len, num_pulses,
        output out, busy, done
    );
endinterface

// File: rtl/pulse_train_generator.sv
// Pulse train generator.
// Emits a programmable train of clean pulses on a registered output and flags
// completion with a one-cycle done strobe. The configuration is captured when a
// start request is accepted in IDLE.
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   slave side of pulse_train_generator_if:
//         start/abort in, high_len/low_len/num_pulses in, out/busy/done out
//
// state | meaning
// IDLE  | waiting for start; out=0, busy=0
// HIGH  | driving a pulse high for max(high_len,1) cycles
// LOW   | gap between pulses for max(low_len,1) cycles
// DONE  | one-cycle completion strobe, busy still high
module pulse_train_generator #(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    pulse_train_generator_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pulses_left;
    logic [CNT_W-1:0] high_cfg;
    logic [CNT_W-1:0] low_cfg;
    logic             out_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             accept;
    logic             phase_end;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    assign accept    = (state == S_IDLE) && bus.start && !bus.abort;
    assign phase_end = (cnt == ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (bus.num_pulses != '0) ? S_HIGH : S_DONE;
                end
            end
            S_HIGH: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (phase_end) begin
                    state_nxt = (pulses_left > ONE) ? S_LOW : S_DONE;
                end
            end
            S_LOW: begin
                if (bus.abort) begin
                    state_nxt = S_IDLE;
                end else if (phase_end) begin
                    state_nxt = S_HIGH;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so out/busy/done
    // come straight from flops and cannot glitch.
    always_comb begin
        out_nxt  = (state_nxt == S_HIGH);
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.out  <= out_nxt;
            bus.busy <= busy_nxt;
            bus.done <= done_nxt;
        end
    end

    // Phase counter counts down to 1, then reloads for the next phase; the
    // remaining-pulse count drops on each HIGH->LOW hand-over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            pulses_left <= '0;
            high_cfg    <= '0;
            low_cfg     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        high_cfg    <= at_least_one(bus.high_len);
                        low_cfg     <= at_least_one(bus.low_len);
                        pulses_left <= bus.num_pulses;
                        cnt         <= at_least_one(bus.high_len);
                    end
                end
                S_HIGH: begin
                    if (phase_end) begin
                        if (pulses_left > ONE) begin
                            cnt         <= low_cfg;
                            pulses_left <= pulses_left - ONE;
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                S_LOW: begin
                    if (phase_end) begin
                        cnt <= high_cfg;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_train_generator.sv
module tb_pulse_train_generator;
    logic clk = 1'b0;
    logic rst;

    pulse_train_generator_if #(.CNT_W(8)) bus ();

    pulse_train_generator #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected {out, done} for each cycle in which busy is high.
    bit [1:0] sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit [1:0] e;
        if (rst) begin
            if (bus.busy) begin
                if (sb.size() == 0) begin
                    check("unexpected_busy", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out", int'(bus.out), int'(e[1]));
                    check("done", int'(bus.done), int'(e[0]));
                end
            end else begin
                check("idle_out", int'(bus.out), 0);
                check("idle_done", int'(bus.done), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a train is n pulses of max(h,1) high cycles, separated by
    // max(l,1) low cycles, followed by one done cycle. An abort issued in busy
    // cycle ab keeps that cycle and drops everything after it.
    task automatic run_train(input int h, input int l, input int n, input int ab, input bit hold);
        bit [1:0] q[$];
        int he, le, total;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        for (int p = 1; p <= n; p++) begin
            repeat (he) q.push_back(2'b10);
            if (p < n) repeat (le) q.push_back(2'b00);
        end
        q.push_back(2'b01);
        total = q.size();
        if (ab >= total) ab = -1;
        if (ab >= 0) total = ab + 1;
        for (int i = 0; i < total; i++) sb.push_back(q[i]);

        bus.high_len   = 8'(h);
        bus.low_len    = 8'(l);
        bus.num_pulses = 8'(n);
        bus.abort      = 1'b0;
        bus.start      = 1'b1;
        tick();
        if (!hold) bus.start = 1'b0;
        // Configuration changes after acceptance must not disturb the train.
        bus.high_len   = 8'($urandom);
        bus.low_len    = 8'($urandom);
        bus.num_pulses = 8'($urandom);
        for (int i = 0; i < total; i++) begin
            bus.abort = (i == ab);
            tick();
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        tick();
        tick();
        check("queue_drained", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, l, n, ab, total;
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.high_len   = '0;
        bus.low_len    = '0;
        bus.num_pulses = '0;
        repeat (3) tick();
        check("reset_out", int'(bus.out), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        rst = 1'b1;
        tick();
        tick();

        run_train(1, 1, 3, -1, 1'b0);
        run_train(3, 2, 2, -1, 1'b0);
        run_train(5, 5, 0, -1, 1'b0);
        run_train(0, 0, 2, -1, 1'b0);
        // abort in the second LOW phase of a 4-pulse train, fresh start 2 cycles on
        run_train(2, 3, 4, 8, 1'b0);
        run_train(2, 1, 2, -1, 1'b0);
        // start held through the train and its done cycle must not retrigger
        run_train(2, 2, 3, -1, 1'b1);
        // abort during the done cycle
        run_train(1, 1, 1, 1, 1'b0);
        run_train(255, 255, 2, -1, 1'b0);
        run_train(1, 255, 3, -1, 1'b0);

        // abort together with start in IDLE: start dropped
        bus.num_pulses = 8'd3;
        bus.high_len   = 8'd2;
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) tick();
        check("abort_start_idle_busy", int'(bus.busy), 0);

        for (int t = 0; t < 30; t++) begin
            h = $urandom_range(0, 6);
            l = $urandom_range(0, 6);
            n = $urandom_range(0, 5);
            total = (n == 0) ? 1 : n * ((h == 0) ? 1 : h) + (n - 1) * ((l == 0) ? 1 : l) + 1;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, total - 1)) : -1;
            run_train(h, l, n, ab, 1'($urandom_range(0, 1)));
        end

        // async reset mid-HIGH with start held high
        bus.high_len   = 8'd4;
        bus.low_len    = 8'd2;
        bus.num_pulses = 8'd3;
        bus.start      = 1'b1;
        repeat (4) sb.push_back(2'b10);
        tick();
        tick();
        tick();
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_out", int'(bus.out), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        check("async_rst_done", int'(bus.done), 0);
        sb.delete();
        bus.start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        repeat (4) tick();
        check("no_resume_busy", int'(bus.busy), 0);
        run_train(1, 2, 2, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
